nx_token_arbiter: RTL and testbench
===================================

// Module: nx_token_arbiter
//
// PURPOSE
// - Owns one outbound message channel token and shares it between REQUESTERS node
//   controllers in a row or column.
// - Hands the token to one node at a time with a single-cycle grant pulse.
// - Waits for that node's release pulse, then passes the token on round-robin.
// - A watchdog reclaims a token that is never released, so the channel cannot deadlock.
//
// PARAMETERS
// - REQUESTERS  4    Number of node controllers sharing the channel; >= 2, need not be a power of 2
// - TIMEOUT     256  Max cycles in HOLD before forced reclaim; 0 disables the watchdog
// - IDX_W       $clog2(REQUESTERS)  Derived; requester index width
//
// PORTS
// - clk_i       in   1           Clock; the block has one clock
// - rst_ni      in   1           Reset; asynchronous, active-low
// - enable_i    in   1           Permit new grants; a grant in progress always completes
// - active_i    in   REQUESTERS  Per-node "has work" hint (node !idle_o)
// - release_i   in   REQUESTERS  Per-node token release pulse
// - grant_o     out  REQUESTERS  One-hot, single-cycle token grant pulse
// - holder_o    out  IDX_W       Index of the current or last holder
// - busy_o      out  1           Token is out: state is ISSUE or HOLD
// - timeout_o   out  1           Single-cycle pulse on forced reclaim
// - error_o     out  1           Sticky; a release arrived from a node that is not the holder
//
// BEHAVIOUR
// - All outputs are registered.
// - Reset values: grant_o=0, holder_o=0, busy_o=0, timeout_o=0, error_o=0, rr pointer=0,
//   timer=0, state=IDLE.
// - FSM states: IDLE -> ISSUE -> HOLD -> IDLE.
// - IDLE, pick rule: when enable_i && |active_i, pick the first set active_i at or after the
//   rr pointer, wrapping from REQUESTERS-1 to 0. Load holder, go to ISSUE.
// - IDLE, no request: if enable_i is low or active_i==0, stay in IDLE and issue no grant.
// - ISSUE: grant_o[holder]=1 for exactly this one cycle. Clear the timer, go to HOLD.
// - HOLD, release: release_i[holder] may arrive on the first HOLD cycle or any later cycle.
//   It moves the rr pointer to holder+1 (mod REQUESTERS) and returns to IDLE.
// - HOLD, watchdog: with TIMEOUT!=0, timer==TIMEOUT-1 pulses timeout_o, moves the pointer to
//   holder+1 and returns to IDLE. The timer saturates and never wraps.
// - Latency: active_i seen in cycle t gives grant_o in t+1. Release seen in cycle r gives the
//   next grant no earlier than r+2.
// - Stray releases: release_i[j], j!=holder, in any state sets error_o and is otherwise ignored.
//   release_i[holder] outside HOLD also sets error_o.
// - Simultaneous release and timeout in the same cycle: the release wins and timeout_o stays 0.
// - enable_i dropping during ISSUE/HOLD does not abort the grant; it only blocks the next pick.
// - active_i changes during HOLD are ignored; it is sampled only in IDLE.
// - Pointer arithmetic is done in IDX_W+1 bits, then compared against REQUESTERS for the wrap.
//   Out-of-range index values are never produced.
// - Reset asserted mid-HOLD returns to the reset state immediately. The requester's own reset
//   is expected to drop its held token.
//
// STRUCTURE
// - Shared package: nx_token_state_t enum {IDLE, ISSUE, HOLD}.
// - Shared package: NX_TOKEN_TIMEOUT_DEFAULT constant.
// - Sub-module nx_rr_picker, purely combinational:
//   - inputs: request vector and base pointer
//   - outputs: found flag and index
//   - reused by later arbiters
// - FSM, timer, pointer and error flag live in this module.
//
// TESTING
// - Single requester, N=4: active_i=4'b0100, release 3 cycles after the grant
//   -> grant_o=4'b0100 one cycle; busy_o for 4 cycles; pointer becomes 3.
// - All active, each node releases on the first HOLD cycle
//   -> grants in order 0,1,2,3,0, spaced 3 cycles apart.
// - N=3 wrap: pointer=2, active_i=3'b011 -> grant index 0, never index 3.
// - TIMEOUT=8, holder never releases -> timeout_o on cycle 8 of HOLD; the next active node is
//   granted 2 cycles later.
// - Release from index 1 while index 2 holds -> error_o=1 (sticky); state unchanged; the
//   holder's later release is accepted.
// - enable_i=0 during HOLD, then release -> no new grant until enable_i=1.
// - rst_ni pulsed low mid-HOLD -> all outputs are 0 asynchronously; FSM restarts with pointer 0.

Source files
------------

// File: rtl/nx_token_pkg.sv
// nx_token_pkg: shared types and constants for the token arbiters.
package nx_token_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} nx_token_state_t;
    localparam int NX_TOKEN_TIMEOUT_DEFAULT = 256;
endpackage

// File: rtl/nx_rr_picker.sv
// nx_rr_picker: combinational round-robin search for the first request at or after base_i.
module nx_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] base_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);
    logic [IDX_W:0] pos;
    // Scan from farthest to nearest so the nearest hit is the one left standing.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, base_i} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
            if (req_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/nx_token_arbiter.sv
// nx_token_arbiter: round-robin owner of one channel token, with grant pulse,
// release handshake and a watchdog that reclaims tokens that are never released.
module nx_token_arbiter
    import nx_token_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int TIMEOUT    = NX_TOKEN_TIMEOUT_DEFAULT,
    parameter int IDX_W      = $clog2(REQUESTERS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [REQUESTERS-1:0] active_i,
    input  logic [REQUESTERS-1:0] release_i,
    output logic [REQUESTERS-1:0] grant_o,
    output logic [IDX_W-1:0]      holder_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic                  error_o
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    nx_token_state_t       state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d, holder_q, holder_d, pick_idx, wrap_ptr;
    logic [IDX_W:0]        next_ptr;
    logic [TW-1:0]         timer_q, timer_d;
    logic [REQUESTERS-1:0] grant_q, grant_d, legal;
    logic                  busy_q, busy_d, timeout_q, timeout_d, error_q, error_d;
    logic                  pick_found, rel_ok, expire;

    nx_rr_picker #(.N(REQUESTERS), .IDX_W(IDX_W)) u_picker (
        .req_i   (active_i),
        .base_i  (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        next_ptr  = {1'b0, holder_q} + (IDX_W + 1)'(1);
        wrap_ptr  = (next_ptr == (IDX_W + 1)'(REQUESTERS)) ? '0 : next_ptr[IDX_W-1:0];
        legal     = (state_q == HOLD) ? REQUESTERS'(1) << holder_q : '0;
        rel_ok    = |(release_i & legal);
        // A release in the same cycle as the deadline wins over the watchdog.
        expire    = (TIMEOUT != 0) && (state_q == HOLD) && !rel_ok && (timer_q == TW'(TIMEOUT - 1));
        state_d   = state_q;
        ptr_d     = ptr_q;
        holder_d  = holder_q;
        timer_d   = timer_q;
        grant_d   = '0;
        timeout_d = 1'b0;
        error_d   = error_q | |(release_i & ~legal);
        case (state_q)
            IDLE: if (enable_i && pick_found) begin
                holder_d = pick_idx;
                grant_d  = REQUESTERS'(1) << pick_idx;
                state_d  = ISSUE;
            end
            ISSUE: begin
                timer_d = '0;
                state_d = HOLD;
            end
            HOLD: begin
                timer_d = &timer_q ? timer_q : timer_q + TW'(1);
                if (rel_ok || expire) begin
                    ptr_d     = wrap_ptr;
                    timeout_d = expire;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            holder_q  <= '0;
            timer_q   <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            holder_q  <= holder_d;
            timer_q   <= timer_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            error_q   <= error_d;
        end
    end

    assign grant_o   = grant_q;
    assign holder_o  = holder_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;
    assign error_o   = error_q;
endmodule

// File: tb/tb_nx_token_arbiter.sv
// tb_nx_token_arbiter: randomized and directed checks of two arbiter instances
// (N=4/TIMEOUT=8 and N=3/TIMEOUT=5) against a transaction-level model.
module tb_nx_token_arbiter;
    typedef struct {
        int phase;  // 0 free, 1 grant cycle, 2 held
        int holder;
        int ptr;
        int age;    // number of the current held cycle, 1-based
        bit err;
        bit tmo;
    } mdl_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       en4 = 1'b0, en3 = 1'b0;
    logic [3:0] act4 = '0, rel4 = '0, g4;
    logic [2:0] act3 = '0, rel3 = '0, g3;
    logic [1:0] h4, h3;
    logic       b4, t4, e4, b3, t3, e3;
    int         checks = 0, failures = 0, cyc = 0;
    mdl_t       m4, m3;

    always #5 clk = ~clk;

    nx_token_arbiter #(.REQUESTERS(4), .TIMEOUT(8)) u4 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en4), .active_i(act4), .release_i(rel4),
        .grant_o(g4), .holder_o(h4), .busy_o(b4), .timeout_o(t4), .error_o(e4)
    );
    nx_token_arbiter #(.REQUESTERS(3), .TIMEOUT(5)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en3), .active_i(act3), .release_i(rel3),
        .grant_o(g3), .holder_o(h3), .busy_o(b3), .timeout_o(t3), .error_o(e3)
    );

    function automatic mdl_t mreset();
        mdl_t m;
        m.phase = 0; m.holder = 0; m.ptr = 0; m.age = 0; m.err = 0; m.tmo = 0;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, int n, int to, bit en, int act, int rel);
        mdl_t r = m;
        r.tmo = 0;
        for (int j = 0; j < n; j++)
            if (((rel >> j) & 1) != 0 && !(m.phase == 2 && j == m.holder)) r.err = 1;
        if (m.phase == 0) begin
            if (en && act != 0) begin
                for (int k = n - 1; k >= 0; k--)
                    if (((act >> ((m.ptr + k) % n)) & 1) != 0) r.holder = (m.ptr + k) % n;
                r.phase = 1;
            end
        end else if (m.phase == 1) begin
            r.phase = 2;
            r.age = 1;
        end else if (((rel >> m.holder) & 1) != 0) begin
            r.ptr = (m.holder + 1) % n;
            r.phase = 0;
        end else if (to != 0 && m.age == to) begin
            r.tmo = 1;
            r.ptr = (m.holder + 1) % n;
            r.phase = 0;
        end else r.age = m.age + 1;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] a, int e);
        checks++;
        if (a !== 32'(e)) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, a, e);
        end
    endtask

    task automatic compare_all();
        chk("u4.grant", 32'(g4), m4.phase == 1 ? (1 << m4.holder) : 0);
        chk("u4.holder", 32'(h4), m4.holder);
        chk("u4.busy", 32'(b4), int'(m4.phase != 0));
        chk("u4.timeout", 32'(t4), int'(m4.tmo));
        chk("u4.error", 32'(e4), int'(m4.err));
        chk("u3.grant", 32'(g3), m3.phase == 1 ? (1 << m3.holder) : 0);
        chk("u3.holder", 32'(h3), m3.holder);
        chk("u3.busy", 32'(b3), int'(m3.phase != 0));
        chk("u3.timeout", 32'(t3), int'(m3.tmo));
        chk("u3.error", 32'(e3), int'(m3.err));
    endtask

    task automatic tick();
        mdl_t n4, n3;
        n4 = rst_n ? step(m4, 4, 8, en4, int'(act4), int'(rel4)) : mreset();
        n3 = rst_n ? step(m3, 3, 5, en3, int'(act3), int'(rel3)) : mreset();
        @(posedge clk);
        #1;
        cyc++;
        m4 = n4;
        m3 = n3;
        compare_all();
    endtask

    initial begin
        int bc, ng, gc, tc, gn, gi;
        int gidx[$];
        int gcyc[$];
        m4 = mreset();
        m3 = mreset();
        repeat (3) tick();
        chk("rst.grant", 32'(g4), 0);
        chk("rst.busy", 32'(b4), 0);
        chk("rst.holder", 32'(h4), 0);
        rst_n = 1'b1;
        tick();
        // single requester, release three cycles after the grant
        en4 = 1'b1; act4 = 4'b0100;
        tick();
        chk("single.grant", 32'(g4), 4);
        act4 = '0;
        bc = int'(b4);
        repeat (3) begin tick(); bc += int'(b4); chk("single.pulse", 32'(g4), 0); end
        rel4 = 4'b0100;
        tick();
        rel4 = '0;
        bc += int'(b4);
        chk("single.busy_cycles", 32'(bc), 4);
        act4 = 4'b1001;
        tick();
        chk("single.ptr3", 32'(h4), 3);
        act4 = '0;
        tick(); rel4 = 4'b1000; tick(); rel4 = '0;
        // all active, release on the first held cycle
        act4 = 4'b1111;
        for (int i = 0; i < 40 && gidx.size() < 5; i++) begin
            rel4 = (m4.phase == 2 && m4.age == 1) ? 4'(1 << m4.holder) : 4'b0;
            tick();
            if (g4 != 0) begin gidx.push_back(int'(h4)); gcyc.push_back(cyc); end
        end
        rel4 = '0;
        chk("rr.count", 32'(gidx.size()), 5);
        for (int i = 0; i < gidx.size(); i++) chk("rr.order", 32'(gidx[i]), i % 4);
        for (int i = 1; i < gcyc.size(); i++) chk("rr.spacing", 32'(gcyc[i] - gcyc[i-1]), 3);
        act4 = '0;
        tick(); rel4 = 4'b0001; tick(); rel4 = '0;
        // watchdog: holder 1 never releases
        act4 = 4'b0011;
        tick();
        chk("to.holder", 32'(h4), 1);
        gc = cyc; tc = -1; gn = -1; gi = -1;
        for (int i = 0; i < 20 && gn < 0; i++) begin
            tick();
            if (t4 && tc < 0) tc = cyc;
            if (g4 != 0 && gn < 0) begin gn = cyc; gi = int'(h4); end
        end
        chk("to.pulse_at", 32'(tc - gc), 9);
        chk("to.next_grant_at", 32'(gn - gc), 10);
        chk("to.next_idx", 32'(gi), 0);
        act4 = '0;
        tick(); rel4 = 4'b0001; tick(); rel4 = '0;
        // stray release while node 2 holds
        act4 = 4'b0100;
        tick();
        act4 = '0;
        tick();
        rel4 = 4'b0010;
        tick();
        rel4 = '0;
        chk("err.set", 32'(e4), 1);
        chk("err.still_busy", 32'(b4), 1);
        chk("err.holder", 32'(h4), 2);
        tick();
        rel4 = 4'b0100;
        tick();
        rel4 = '0;
        chk("err.release_ok", 32'(b4), 0);
        chk("err.sticky", 32'(e4), 1);
        // enable dropped during hold
        act4 = 4'b1111;
        tick();
        en4 = 1'b0;
        tick(); rel4 = 4'b1000; tick(); rel4 = '0;
        ng = 0;
        repeat (5) begin tick(); ng += int'(g4 != 0); end
        chk("en.blocked", 32'(ng), 0);
        en4 = 1'b1;
        tick();
        chk("en.resume", 32'(g4), 1);
        tick();
        // asynchronous reset in the middle of a hold
        #3 rst_n = 1'b0;
        #1;
        chk("arst.grant", 32'(g4), 0);
        chk("arst.busy", 32'(b4), 0);
        chk("arst.holder", 32'(h4), 0);
        chk("arst.error", 32'(e4), 0);
        chk("arst.timeout", 32'(t4), 0);
        m4 = mreset(); m3 = mreset();
        act4 = 4'b1010;
        rst_n = 1'b1;
        tick();
        chk("arst.ptr0", 32'(h4), 1);
        act4 = '0;
        tick(); rel4 = 4'b0010; tick(); rel4 = '0;
        // N=3 pointer wrap
        en3 = 1'b1; act3 = 3'b010;
        tick();
        act3 = '0;
        tick(); rel3 = 3'b010; tick(); rel3 = '0;
        act3 = 3'b011;
        tick();
        chk("n3.wrap_idx", 32'(h3), 0);
        chk("n3.wrap_grant", 32'(g3), 1);
        act3 = '0;
        tick(); rel3 = 3'b001; tick(); rel3 = '0;
        // release coincides with the watchdog deadline
        act3 = 3'b100;
        tick();
        act3 = '0;
        repeat (5) tick();
        rel3 = 3'b100;
        tick();
        rel3 = '0;
        chk("n3.rel_beats_timeout", 32'(t3), 0);
        chk("n3.rel_idle", 32'(b3), 0);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            en4 = $urandom_range(0, 7) != 0;
            en3 = $urandom_range(0, 7) != 0;
            act4 = 4'($urandom);
            act3 = 3'($urandom);
            rel4 = (m4.phase == 2 && $urandom_range(0, 3) == 0) ? 4'(1 << m4.holder) : 4'b0;
            rel3 = (m3.phase == 2 && $urandom_range(0, 3) == 0) ? 3'(1 << m3.holder) : 3'b0;
            if (i > 500 && $urandom_range(0, 60) == 0) rel4 = rel4 | 4'(1 << $urandom_range(0, 3));
            if (i > 500 && $urandom_range(0, 60) == 0) rel3 = rel3 | 3'(1 << $urandom_range(0, 2));
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
